mul_iter_unit: RTL

Iterative shift-add multiply unit for the multicycle ARM datapath. It is parametrised in operand width and supports MUL, MLA, UMULL and SMULL. It takes the multiply path out of the single-cycle ALU, so the datapath clock no longer carries a WIDTH×WIDTH combinational multiplier. The controller launches an operation with start, waits for done, then writes result_lo to Rd and result_hi to Ra (long forms) over the existing register-file ports.

---
 rtl/mul_iter_unit_if.sv | 27 ++
 rtl/mul_iter_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mul_iter_unit_if.sv
// Handshake and result bundle between the multicycle controller and the
// iterative multiply unit.
interface mul_iter_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] acc;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             flag_n;
   logic             flag_z;

   modport master (
      output start, op, a, b, acc,
      input  busy, done, result_lo, result_hi, flag_n, flag_z
   );

   modport slave (
      input  start, op, a, b, acc,
      output busy, done, result_lo, result_hi, flag_n, flag_z
   );
endinterface

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier (MUL, MLA, UMULL, SMULL) for the multicycle
// ARM datapath: one partial product per cycle, then a sign/accumulate fix-up.
module mul_iter_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic           clk,
   input  logic           reset,
   mul_iter_unit_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MLA   = 2'b01;
   localparam logic [1:0] OP_SMULL = 2'b11;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_op;
   logic               r_neg;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH:0]     r_mcand;
   logic [WIDTH:0]     r_mplier;
   logic [2*WIDTH-1:0] r_prod;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_res_lo;
   logic [WIDTH-1:0]   r_res_hi;
   logic               r_flag_n;
   logic               r_flag_z;

   logic [WIDTH:0]     w_a_ext;
   logic [WIDTH:0]     w_b_ext;
   logic [WIDTH:0]     w_mag_a;
   logic [WIDTH:0]     w_mag_b;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic               w_long;
   logic [WIDTH-1:0]   w_fix_lo;
   logic [WIDTH-1:0]   w_fix_hi;
   logic               w_fix_n;
   logic               w_fix_z;

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: w_state_nxt = bus.start ? S_RUN : S_IDLE;
         S_RUN:          if (r_cnt == CNT_W'(1)) w_state_nxt = S_FIX;
         S_FIX:          w_state_nxt = S_DONE;
         default:        w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // WIDTH+1-bit magnitudes so that -2^(WIDTH-1) is representable exactly.
   always_comb begin
      w_a_ext = {bus.a[WIDTH-1], bus.a};
      w_b_ext = {bus.b[WIDTH-1], bus.b};
      w_mag_a = bus.a[WIDTH-1] ? (WIDTH+1)'(0) - w_a_ext : w_a_ext;
      w_mag_b = bus.b[WIDTH-1] ? (WIDTH+1)'(0) - w_b_ext : w_b_ext;
   end

   // Partial-product add into the upper half, keeping the carry for the shift.
   always_comb begin
      w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? r_mcand : '0);
   end

   always_comb begin
      w_long     = r_op[1];
      w_prod_fix = r_neg ? (2*WIDTH)'(0) - r_prod : r_prod;
      w_fix_lo   = w_prod_fix[WIDTH-1:0] + ((r_op == OP_MLA) ? r_acc : '0);
      w_fix_hi   = w_long ? w_prod_fix[2*WIDTH-1:WIDTH] : '0;
      w_fix_n    = w_long ? w_prod_fix[2*WIDTH-1] : w_fix_lo[WIDTH-1];
      w_fix_z    = w_long ? (w_prod_fix == '0) : (w_fix_lo == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op     <= OP_MUL;
         r_neg    <= 1'b0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
         r_res_lo <= '0;
         r_res_hi <= '0;
         r_flag_n <= 1'b0;
         r_flag_z <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_op   <= bus.op;
                  r_acc  <= bus.acc;
                  r_prod <= '0;
                  r_cnt  <= CNT_W'(WIDTH);
                  if (bus.op == OP_SMULL) begin
                     r_mcand  <= w_mag_a;
                     r_mplier <= w_mag_b;
                     r_neg    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  end else begin
                     r_mcand  <= {1'b0, bus.a};
                     r_mplier <= {1'b0, bus.b};
                     r_neg    <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               r_prod   <= {w_sum, r_prod[WIDTH-1:1]};
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt - CNT_W'(1);
            end
            S_FIX: begin
               r_res_lo <= w_fix_lo;
               r_res_hi <= w_fix_hi;
               r_flag_n <= w_fix_n;
               r_flag_z <= w_fix_z;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (r_state == S_RUN) || (r_state == S_FIX);
   assign bus.done      = (r_state == S_DONE);
   assign bus.result_lo = r_res_lo;
   assign bus.result_hi = r_res_hi;
   assign bus.flag_n    = r_flag_n;
   assign bus.flag_z    = r_flag_z;

endmodule
